// File: rtl/axil_sram_if.sv
// -----------------------------------------------------------------------------
// axil_sram_if
// AXI4-Lite channel bundle between the core's load/store path (master) and
// the axil_sram memory slave.
//   AR : mem_arvalid, mem_arready, mem_araddr[31:0]
//   R  : mem_rvalid, mem_rready, mem_rdata[31:0], mem_rresp[1:0]
//   AW : mem_awvalid, mem_awready, mem_awaddr[31:0]
//   W  : mem_wvalid, mem_wready, mem_wdata[31:0], mem_wstrb[7:0]
//   B  : mem_bvalid, mem_bready, mem_bresp[1:0]
// Handshake: a beat transfers on a rising clock edge where both valid and
// ready are high. Once raised, valid and its payload stay stable until that
// edge. Ready may be raised before valid.
// -----------------------------------------------------------------------------
interface axil_sram_if;
  logic        mem_arvalid;
  logic        mem_arready;
  logic [31:0] mem_araddr;

  logic        mem_rvalid;
  logic        mem_rready;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;

  logic        mem_awvalid;
  logic        mem_awready;
  logic [31:0] mem_awaddr;

  logic        mem_wvalid;
  logic        mem_wready;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wstrb;

  logic        mem_bvalid;
  logic        mem_bready;
  logic [1:0]  mem_bresp;

  modport master (
    output mem_arvalid, mem_araddr, mem_rready,
    output mem_awvalid, mem_awaddr, mem_wvalid, mem_wdata, mem_wstrb, mem_bready,
    input  mem_arready, mem_rvalid, mem_rdata, mem_rresp,
    input  mem_awready, mem_wready, mem_bvalid, mem_bresp
  );

  modport slave (
    input  mem_arvalid, mem_araddr, mem_rready,
    input  mem_awvalid, mem_awaddr, mem_wvalid, mem_wdata, mem_wstrb, mem_bready,
    output mem_arready, mem_rvalid, mem_rdata, mem_rresp,
    output mem_awready, mem_wready, mem_bvalid, mem_bresp
  );
endinterface

// File: rtl/axil_sram.sv
// -----------------------------------------------------------------------------
// axil_sram
// AXI4-Lite word-addressed memory slave with independent read and write
// state machines and programmable response latency.
// Ports:
//   clk         : clock, all state on rising edge
//   rst         : asynchronous, active-low reset
//   bus         : axil_sram_if.slave (AR/R/AW/W/B channels)
//   rd_state_o  : read FSM state (0 idle, 1 wait, 2 resp)
//   wr_state_o  : write FSM state (0 idle, 1 wait, 2 resp)
// Parameters:
//   DEPTH  : words of storage (power of two, >= 2)
//   BASE   : byte address of word 0
//   RD_LAT : idle cycles between AR handshake and rvalid (0..15)
//   WR_LAT : idle cycles between write capture and bvalid (0..15)
// All bus outputs come straight from flops.
// -----------------------------------------------------------------------------
module axil_sram #(
  parameter int unsigned DEPTH  = 4096,
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned WR_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  axil_sram_if.slave bus,
  output logic [1:0] rd_state_o,
  output logic [1:0] wr_state_o
);

  localparam int unsigned IW          = $clog2(DEPTH);
  localparam logic [31:0] SPAN        = 32'(DEPTH * 4);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} rd_state_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} wr_state_e;

  // Storage is intentionally not reset.
  logic [31:0] mem_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Address decode. The explicit lower-bound compare keeps addresses below
  // BASE from wrapping into the window.
  // ---------------------------------------------------------------------------
  logic [31:0] ar_off, aw_off;
  logic        ar_hit, aw_hit;

  assign ar_off = bus.mem_araddr - BASE;
  assign aw_off = bus.mem_awaddr - BASE;
  assign ar_hit = (bus.mem_araddr >= BASE) && (ar_off < SPAN);
  assign aw_hit = (bus.mem_awaddr >= BASE) && (aw_off < SPAN);

  // Strobe bits [7:4] have no lanes behind them.
  logic unused_wstrb_hi;
  assign unused_wstrb_hi = ^bus.mem_wstrb[7:4];

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  rd_state_e   rd_state_q;
  logic [3:0]  rcnt_q;
  logic [IW-1:0] ridx_q;
  logic        rhit_q;
  logic        arready_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state_q <= R_IDLE;
      rcnt_q     <= '0;
      ridx_q     <= '0;
      rhit_q     <= 1'b0;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      unique case (rd_state_q)
        R_IDLE: begin
          if (bus.mem_arvalid && arready_q) begin
            ridx_q     <= ar_off[IW+1:2];
            rhit_q     <= ar_hit;
            rcnt_q     <= 4'(RD_LAT);
            arready_q  <= 1'b0;
            rd_state_q <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (rcnt_q == 4'd0) begin
            // Sampled with the pre-edge storage value, so a write committing
            // on the same edge is not visible here.
            rdata_q    <= rhit_q ? mem_q[ridx_q] : 32'h0;
            rresp_q    <= rhit_q ? RESP_OKAY : RESP_DECERR;
            rvalid_q   <= 1'b1;
            rd_state_q <= R_RESP;
          end else begin
            rcnt_q <= rcnt_q - 4'd1;
          end
        end
        R_RESP: begin
          if (bus.mem_rready) begin
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= R_IDLE;
          end
        end
        default: begin
          rvalid_q   <= 1'b0;
          arready_q  <= 1'b1;
          rd_state_q <= R_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write FSM. AW and W are captured independently while idle; a channel's
  // ready dropping low in W_IDLE means its beat is already held.
  // ---------------------------------------------------------------------------
  wr_state_e   wr_state_q;
  logic [3:0]  wcnt_q;
  logic [IW-1:0] widx_q;
  logic        whit_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        awready_q;
  logic        wready_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q;

  logic aw_hs, w_hs, have_aw, have_w, commit;

  assign aw_hs   = bus.mem_awvalid && awready_q;
  assign w_hs    = bus.mem_wvalid && wready_q;
  assign have_aw = aw_hs || !awready_q;
  assign have_w  = w_hs || !wready_q;
  assign commit  = (wr_state_q == W_WAIT) && (wcnt_q == 4'd0) && whit_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state_q <= W_IDLE;
      wcnt_q     <= '0;
      widx_q     <= '0;
      whit_q     <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b1;
      wready_q   <= 1'b1;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      unique case (wr_state_q)
        W_IDLE: begin
          if (aw_hs) begin
            widx_q    <= aw_off[IW+1:2];
            whit_q    <= aw_hit;
            awready_q <= 1'b0;
          end
          if (w_hs) begin
            wdata_q  <= bus.mem_wdata;
            wstrb_q  <= bus.mem_wstrb[3:0];
            wready_q <= 1'b0;
          end
          if (have_aw && have_w) begin
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            wcnt_q     <= 4'(WR_LAT);
            wr_state_q <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (wcnt_q == 4'd0) begin
            bresp_q    <= whit_q ? RESP_OKAY : RESP_DECERR;
            bvalid_q   <= 1'b1;
            wr_state_q <= W_RESP;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        W_RESP: begin
          if (bus.mem_bready) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            wr_state_q <= W_IDLE;
          end
        end
        default: begin
          bvalid_q   <= 1'b0;
          awready_q  <= 1'b1;
          wready_q   <= 1'b1;
          wr_state_q <= W_IDLE;
        end
      endcase
    end
  end

  // Byte-masked commit on the same edge that raises bvalid.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem_q[widx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.mem_arready = arready_q;
  assign bus.mem_rvalid  = rvalid_q;
  assign bus.mem_rdata   = rdata_q;
  assign bus.mem_rresp   = rresp_q;
  assign bus.mem_awready = awready_q;
  assign bus.mem_wready  = wready_q;
  assign bus.mem_bvalid  = bvalid_q;
  assign bus.mem_bresp   = bresp_q;

  assign rd_state_o = rd_state_q;
  assign wr_state_o = wr_state_q;

endmodule

// File: doc/axil_sram.md
# axil_sram

Single-port-per-channel AXI4-Lite memory slave that sits directly downstream of the core's load/store path: it terminates the `mem_aw*/mem_w*/mem_b*/mem_ar*/mem_r*` channels driven by the write-back/memory stage and returns raw 32-bit words that the core's byte-lane extractor post-processes. Read and write channels run independent state machines with parameterised response latency, so the core's handshake logic is exercised under multi-cycle memory timing.

## Interface
- `DEPTH`, 4096: storage size in 32-bit words (power of two).
- `BASE`, 32'h8000_0000: byte address of word 0.
- `RD_LAT`, 2: idle cycles between AR handshake and `rvalid` (0..15).
- `WR_LAT`, 2: idle cycles between write capture complete and `bvalid` (0..15).

- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `mem_arvalid` in 1 / `mem_arready` out 1 / `mem_araddr` in 32: read address channel.
- `mem_rvalid` out 1 / `mem_rready` in 1 / `mem_rdata` out 32 / `mem_rresp` out 2: read data channel.
- `mem_awvalid` in 1 / `mem_awready` out 1 / `mem_awaddr` in 32: write address channel.
- `mem_wvalid` in 1 / `mem_wready` out 1 / `mem_wdata` in 32 / `mem_wstrb` in 8: write data channel; bits [7:4] ignored, bit i enables byte lane i.
- `mem_bvalid` out 1 / `mem_bready` in 1 / `mem_bresp` out 2: write response channel.

## Operation
- Address decode: in range iff `BASE <= addr < BASE + 4*DEPTH`; index = `(addr - BASE) >> 2`; addr[1:0] ignored (word access, lane selection by strobes/core extractor).
- Responses: OKAY = 2'b00, DECERR = 2'b11 for out-of-range.
- Read FSM: R_IDLE (`arready`=1) → on `arvalid&&arready` latch addr, load counter with RD_LAT → R_WAIT (`arready`=0), decrement each cycle → at count 0 sample storage into `rdata`, set `rresp` → R_RESP (`rvalid`=1, `rdata`/`rresp` held stable) → on `rready` → R_IDLE. Out-of-range: `rdata`=0, DECERR.
- Write FSM: W_IDLE: `awready`=1 until AW captured, `wready`=1 until W captured, independently, either order or same cycle. Once both held → W_WAIT, counter loaded with WR_LAT → at count 0 commit masked bytes (in-range only), set `bresp` → W_RESP (`bvalid`=1, both readies 0) → on `bready` → W_IDLE.
- In W_WAIT/W_RESP `awready`=`wready`=0; in R_WAIT/R_RESP `arready`=0. At most one outstanding read and one outstanding write.
- Read-write ordering: if read sample and write commit land in the same cycle on the same index, read returns pre-write data. Later reads see the write.
- Storage contents not reset; undefined until written.

## Timing
- Reset (asynchronous assert, any state): read and write FSMs to IDLE; `arready`=`awready`=`wready`=1; `rvalid`=`bvalid`=0; `rdata`=0; `rresp`=`bresp`=0. In-flight transactions discarded, no storage write.
- Read latency: AR handshake at edge T → `rvalid` high after edge T+1+RD_LAT. RD_LAT=0 → `rvalid` visible the cycle after handshake.
- Write latency: later of AW/W handshake at edge T → storage write and `bvalid` at edge T+1+WR_LAT.
- `rvalid`/`bvalid` stay high with payload stable until accepted; `rready`/`bready` asserted early (before valid) are legal.
- Back-to-back: after R handshake at edge T, `arready`=1 from T, next AR accepted at T+1 earliest; same for B.
- Outputs are registered; no combinational path from any input to any output.

## Test plan
- Reset mid-read: AR 0x8000_0010 accepted, assert `rst`=0 during R_WAIT → `rvalid`=0, `arready`=1 immediately; after release new read completes normally.
- Write/readback: write 0xDEADBEEF strb 0xF to 0x8000_0004, then `wdata`=0x000000AA strb 0x1 same addr → read returns 0xDEADBEAA, OKAY, `rvalid` exactly RD_LAT+1 cycles after AR.
- Split AW/W: W presented 3 cycles before AW → `wready` drops after W handshake, `bvalid` WR_LAT+1 cycles after AW handshake; strb 0xF0 (upper bits only) → memory unchanged.
- Out-of-range: read 0x7FFF_FFFC and write 0x8000_4000 (DEPTH=4096) → `rresp`=`bresp`=2'b11, `rdata`=0, storage unchanged.
- Backpressure: hold `rready`=0 for 5 cycles → `rvalid`, `rdata` stable, `arready`=0; new AR not accepted until after R handshake.
- Collision: RD_LAT=WR_LAT=0, old word 0x11111111, write 0x22222222 and read same addr completing same cycle → read returns 0x11111111; next read 0x22222222.
